// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and registered in_ready.
// A flush turns held entries into bubbles. bubble_cnt counts ready cycles that had no valid output.
module pipe_stage_skid #(
    parameter int                 DATA_W              = 102,
    parameter int                 CTRL_W              = 6,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE         = '0,
    parameter bit                 CLEAR_DATA_ON_FLUSH = 1'b1,
    parameter int                 CNT_W               = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // The state encoding equals the occupancy, so occupancy comes straight from the state flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
    logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
    logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [CNT_W-1:0]    r_bubble_cnt;
    logic                w_accept;
    logic                w_xfer;

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_main_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        if (flush) begin
            w_state_nxt     = S_EMPTY;
            w_main_ctrl_nxt = CTRL_BUBBLE;
            w_skid_ctrl_nxt = CTRL_BUBBLE;
            if (CLEAR_DATA_ON_FLUSH) begin
                w_main_data_nxt = '0;
                w_skid_data_nxt = '0;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = S_HALF;
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end
                end
                S_HALF: begin
                    if (w_accept && w_xfer) begin
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end else if (w_accept) begin
                        w_state_nxt     = S_FULL;
                        w_skid_data_nxt = in_data;
                        w_skid_ctrl_nxt = in_ctrl;
                    end else if (w_xfer) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_xfer) begin
                        w_state_nxt     = S_HALF;
                        w_main_data_nxt = r_skid_data;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_skid_data_nxt = '0;
                        w_skid_ctrl_nxt = CTRL_BUBBLE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // out_valid and in_ready are registered copies decoded from the next state.
    // This keeps backpressure off every combinational path between stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= CTRL_BUBBLE;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_BUBBLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_FULL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main_data;
    assign out_ctrl   = r_out_valid ? r_main_ctrl : CTRL_BUBBLE;
    assign occupancy  = r_state;
    assign bubble_cnt = r_bubble_cnt;

endmodule
